// File: rtl/cra_word_sequencer_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the limb sequencer.
package cra_word_sequencer_pkg;

    localparam int unsigned LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Limb index width; at least one bit so a 1-limb build still has a register.
    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/cra_word_sequencer_if.sv
// Host-side request/result bundle for the multi-precision add/subtract sequencer.
interface cra_word_sequencer_if #(
    parameter int unsigned WORDS = 4
);
    import cra_word_sequencer_pkg::*;

    localparam int unsigned DATA_W = LIMB_W * WORDS;

    logic              start;
    logic              ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              c_in;
    logic              sub;
    logic [DATA_W-1:0] sum;
    logic              c_out;
    logic              overflow;
    logic              done;

    modport master (
        output start, a, b, c_in, sub,
        input  ready, sum, c_out, overflow, done
    );

    modport slave (
        input  start, a, b, c_in, sub,
        output ready, sum, c_out, overflow, done
    );

endinterface

// File: rtl/sixteen_CRA.sv
// 16-bit combinational ripple-carry adder used as the shared limb datapath.
module sixteen_CRA
    import cra_word_sequencer_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              c_in,
    output logic [LIMB_W-1:0] sum,
    output logic              c_out
);

    logic [LIMB_W:0] carry;

    assign carry[0] = c_in;

    // One full adder per bit, carry rippling upward.
    for (genvar i = 0; i < LIMB_W; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[LIMB_W];

endmodule

// File: rtl/cra_word_sequencer.sv
// Multi-precision add/subtract: one 16-bit limb per clock, LSB first, carry chained in a register.
module cra_word_sequencer
    import cra_word_sequencer_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    cra_word_sequencer_if.slave bus
);

    localparam int unsigned DATA_W   = LIMB_W * WORDS;
    localparam int unsigned IDX_W    = idx_width(WORDS);
    localparam int unsigned LAST_IDX = WORDS - 1;

    state_e              state, state_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic                carry, carry_n;
    logic                sub_q, sub_n;
    logic [DATA_W-1:0]   a_q, a_n;
    logic [DATA_W-1:0]   b_q, b_n;
    logic [DATA_W-1:0]   shadow, shadow_n;
    logic [DATA_W-1:0]   sum_q, sum_n;
    logic                c_out_q, c_out_n;
    logic                ovf_q, ovf_n;
    logic                ready_q, ready_n;
    logic                done_q, done_n;

    logic [31:0]         base;
    logic [LIMB_W-1:0]   limb_x;
    logic [LIMB_W-1:0]   limb_y;
    logic [LIMB_W-1:0]   limb_s;
    logic                limb_c;

    // Current limb selection; subtraction feeds the inverted b limb.
    assign base   = LIMB_W * 32'(idx);
    assign limb_x = a_q[base +: LIMB_W];
    assign limb_y = b_q[base +: LIMB_W] ^ {LIMB_W{sub_q}};

    sixteen_CRA u_cra (
        .a     (limb_x),
        .b     (limb_y),
        .c_in  (carry),
        .sum   (limb_s),
        .c_out (limb_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        carry_n  = carry;
        sub_n    = sub_q;
        a_n      = a_q;
        b_n      = b_q;
        shadow_n = shadow;
        sum_n    = sum_q;
        c_out_n  = c_out_q;
        ovf_n    = ovf_q;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    a_n     = bus.a;
                    b_n     = bus.b;
                    sub_n   = bus.sub;
                    carry_n = bus.sub | bus.c_in;
                    idx_n   = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                shadow_n[base +: LIMB_W] = limb_s;
                carry_n = limb_c;
                idx_n   = idx + IDX_W'(1);
                if (idx == IDX_W'(LAST_IDX)) begin
                    idx_n   = '0;
                    state_n = DONE;
                    sum_n   = shadow_n;
                    c_out_n = limb_c;
                    ovf_n   = (a_q[DATA_W-1] == (b_q[DATA_W-1] ^ sub_q)) &&
                              (limb_s[LIMB_W-1] != a_q[DATA_W-1]);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        ready_n = (state_n == IDLE);
        done_n  = (state_n == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            shadow  <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            carry   <= carry_n;
            sub_q   <= sub_n;
            a_q     <= a_n;
            b_q     <= b_n;
            shadow  <= shadow_n;
            sum_q   <= sum_n;
            c_out_q <= c_out_n;
            ovf_q   <= ovf_n;
            ready_q <= ready_n;
            done_q  <= done_n;
        end
    end

    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.c_out    = c_out_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_cra_word_sequencer.sv
// Bench for cra_word_sequencer: directed corner cases at WORDS=4, random sweeps at WORDS=2 and 8.
module tb_cra_word_sequencer;

    logic         clk;
    logic         rst_n;
    int           sel_w;
    logic         start_v;
    logic         cin_v;
    logic         sub_v;
    logic [127:0] a_v;
    logic [127:0] b_v;

    logic [127:0] obs_sum;
    logic         obs_co;
    logic         obs_ov;
    logic         obs_done;
    logic         obs_ready;

    int           checks;
    int           errors;
    logic [127:0] last_exp4;

    cra_word_sequencer_if #(.WORDS(2)) if2 ();
    cra_word_sequencer_if #(.WORDS(4)) if4 ();
    cra_word_sequencer_if #(.WORDS(8)) if8 ();

    cra_word_sequencer #(.WORDS(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    cra_word_sequencer #(.WORDS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    cra_word_sequencer #(.WORDS(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    assign if2.start = start_v && (sel_w == 2);
    assign if2.a     = a_v[31:0];
    assign if2.b     = b_v[31:0];
    assign if2.c_in  = cin_v;
    assign if2.sub   = sub_v;
    assign if4.start = start_v && (sel_w == 4);
    assign if4.a     = a_v[63:0];
    assign if4.b     = b_v[63:0];
    assign if4.c_in  = cin_v;
    assign if4.sub   = sub_v;
    assign if8.start = start_v && (sel_w == 8);
    assign if8.a     = a_v;
    assign if8.b     = b_v;
    assign if8.c_in  = cin_v;
    assign if8.sub   = sub_v;

    always_comb begin
        case (sel_w)
            2: begin
                obs_sum = {96'b0, if2.sum}; obs_co = if2.c_out; obs_ov = if2.overflow;
                obs_done = if2.done; obs_ready = if2.ready;
            end
            8: begin
                obs_sum = if8.sum; obs_co = if8.c_out; obs_ov = if8.overflow;
                obs_done = if8.done; obs_ready = if8.ready;
            end
            default: begin
                obs_sum = {64'b0, if4.sum}; obs_co = if4.c_out; obs_ov = if4.overflow;
                obs_done = if4.done; obs_ready = if4.ready;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer arithmetic on nbits-wide operands, overflow = result not representable.
    function automatic void ref_model(input int nbits, input logic [127:0] a, input logic [127:0] b,
                                      input logic cin, input logic sb,
                                      output logic [127:0] s, output logic co, output logic ov);
        logic [127:0] mask;
        logic [129:0] ua, ub, sa, sbx, t, u;
        mask = '0;
        for (int i = 0; i < nbits; i++) mask[i] = 1'b1;
        ua  = {2'b0, a & mask};
        ub  = {2'b0, b & mask};
        sa  = ua;
        sbx = ub;
        for (int i = nbits; i < 130; i++) begin
            sa[i]  = a[nbits-1];
            sbx[i] = b[nbits-1];
        end
        if (sb) begin
            t  = sa - sbx;
            co = (ua >= ub);
        end else begin
            t  = sa + sbx + 130'(cin);
            u  = ua + ub + 130'(cin);
            co = u[nbits];
        end
        s  = t[127:0] & mask;
        ov = (t[nbits] != t[nbits-1]);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drives one operation on the selected instance and records what came back and when.
    task automatic run_op(input int n, input logic [127:0] a, input logic [127:0] b,
                          input logic cin, input logic sb, input logic [127:0] prev,
                          output logic [127:0] s, output logic co, output logic ov,
                          output int done_at, output int ready_at, output int pulses,
                          output logic held_ok);
        @(negedge clk);
        sel_w = n; a_v = a; b_v = b; cin_v = cin; sub_v = sb; start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        done_at = -1; ready_at = -1; pulses = 0; held_ok = 1'b1;
        s = '0; co = 1'b0; ov = 1'b0;
        for (int e = 1; e <= n + 2; e++) begin
            a_v = rand128(); b_v = rand128();
            cin_v = 1'($urandom()); sub_v = 1'($urandom());
            @(negedge clk);
            if (obs_done === 1'b1) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = e; s = obs_sum; co = obs_co; ov = obs_ov;
                end
            end else if (done_at < 0 && obs_sum !== prev) begin
                held_ok = 1'b0;
            end
            if (obs_ready === 1'b1 && ready_at < 0) ready_at = e;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_v = 1'b0; sel_w = 4;
        a_v = '0; b_v = '0; cin_v = 1'b0; sub_v = 1'b0;
        #12;
        checks += 5;
        if (obs_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", obs_ready); end
        if (obs_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", obs_done); end
        if (obs_sum !== 128'd0) begin errors++; $display("FAIL reset_sum got %h want 0", obs_sum); end
        if (obs_co !== 1'b0) begin errors++; $display("FAIL reset_c_out got %b want 0", obs_co); end
        if (obs_ov !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", obs_ov); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", obs_ready); end
        last_exp4 = '0;
    endtask

    task automatic test_limb_carry();
        logic [127:0] s; logic co, ov, held; int d, r, p;
        run_op(4, 128'h0000_0000_0000_FFFF, 128'h1, 1'b0, 1'b0, last_exp4, s, co, ov, d, r, p, held);
        checks += 7;
        if (s !== 128'h0000_0000_0001_0000) begin errors++; $display("FAIL limb_carry_sum got %h want 10000", s); end
        if (co !== 1'b0) begin errors++; $display("FAIL limb_carry_c_out got %b want 0", co); end
        if (ov !== 1'b0) begin errors++; $display("FAIL limb_carry_ovf got %b want 0", ov); end
        if (d !== 4) begin errors++; $display("FAIL done_latency got %0d want 4", d); end
        if (r !== 5) begin errors++; $display("FAIL ready_latency got %0d want 5", r); end
        if (p !== 1) begin errors++; $display("FAIL done_pulses got %0d want 1", p); end
        if (held !== 1'b1) begin errors++; $display("FAIL sum_held got %b want 1", held); end
        last_exp4 = 128'h0000_0000_0001_0000;
    endtask

    task automatic test_add_edges();
        logic [127:0] s; logic co, ov, held; int d, r, p;
        run_op(4, 128'hFFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0, last_exp4, s, co, ov, d, r, p, held);
        checks += 4;
        if (s !== 128'h0) begin errors++; $display("FAIL wrap_sum got %h want 0", s); end
        if (co !== 1'b1) begin errors++; $display("FAIL wrap_c_out got %b want 1", co); end
        if (ov !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %b want 0", ov); end
        if (held !== 1'b1) begin errors++; $display("FAIL wrap_held got %b want 1", held); end
        last_exp4 = 128'h0;
        run_op(4, 128'h7FFF_FFFF_FFFF_FFFF, 128'h0, 1'b1, 1'b0, last_exp4, s, co, ov, d, r, p, held);
        checks += 3;
        if (s !== 128'h8000_0000_0000_0000) begin errors++; $display("FAIL cin_ovf_sum got %h want 8000000000000000", s); end
        if (co !== 1'b0) begin errors++; $display("FAIL cin_ovf_c_out got %b want 0", co); end
        if (ov !== 1'b1) begin errors++; $display("FAIL cin_ovf_ovf got %b want 1", ov); end
        last_exp4 = 128'h8000_0000_0000_0000;
    endtask

    task automatic test_sub();
        logic [127:0] s; logic co, ov, held; int d, r, p;
        run_op(4, 128'h0, 128'h1, 1'b0, 1'b1, last_exp4, s, co, ov, d, r, p, held);
        checks += 3;
        if (s !== 128'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sub_borrow_sum got %h want ffffffffffffffff", s); end
        if (co !== 1'b0) begin errors++; $display("FAIL sub_borrow_c_out got %b want 0", co); end
        if (ov !== 1'b0) begin errors++; $display("FAIL sub_borrow_ovf got %b want 0", ov); end
        last_exp4 = 128'hFFFF_FFFF_FFFF_FFFF;
        run_op(4, 128'h8000_0000_0000_0000, 128'h1, 1'b1, 1'b1, last_exp4, s, co, ov, d, r, p, held);
        checks += 4;
        if (s !== 128'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sub_ovf_sum got %h want 7fffffffffffffff", s); end
        if (co !== 1'b1) begin errors++; $display("FAIL sub_ovf_c_out got %b want 1", co); end
        if (ov !== 1'b1) begin errors++; $display("FAIL sub_ovf_ovf got %b want 1", ov); end
        if (d !== 4) begin errors++; $display("FAIL sub_done_latency got %0d want 4", d); end
        last_exp4 = 128'h7FFF_FFFF_FFFF_FFFF;
    endtask

    task automatic test_back_to_back();
        logic [127:0] qa[$], qb[$];
        logic         qc[$], qs[$];
        logic [127:0] ea, eb, es, last;
        logic         ec, esb, eco, eov;
        int           accepts, dones;
        accepts = 0; dones = 0; last = last_exp4;
        @(negedge clk);
        sel_w = 4; start_v = 1'b1;
        for (int cyc = 0; cyc < 36; cyc++) begin
            if (cyc >= 26) start_v = 1'b0;
            if (obs_done === 1'b1) begin
                dones++;
                checks++;
                if (qa.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected_done got done=1 want no pending op");
                end else begin
                    ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front(); esb = qs.pop_front();
                    ref_model(64, ea, eb, ec, esb, es, eco, eov);
                    if (obs_sum !== es || obs_co !== eco || obs_ov !== eov) begin
                        errors++;
                        $display("FAIL b2b_result got %h/%b/%b want %h/%b/%b", obs_sum, obs_co, obs_ov, es, eco, eov);
                    end
                    last = es;
                end
            end else if (cyc < 26) begin
                checks++;
                if (obs_sum !== last) begin errors++; $display("FAIL b2b_sum_held got %h want %h", obs_sum, last); end
            end
            if (cyc < 26) begin
                a_v = {64'b0, rand128() & 128'hFFFF_FFFF_FFFF_FFFF};
                b_v = {64'b0, rand128() & 128'hFFFF_FFFF_FFFF_FFFF};
                cin_v = 1'($urandom()); sub_v = 1'($urandom());
                if (obs_ready === 1'b1) begin
                    qa.push_back(a_v); qb.push_back(b_v); qc.push_back(cin_v); qs.push_back(sub_v);
                    accepts++;
                end
            end
            @(negedge clk);
        end
        checks += 2;
        if (dones !== accepts) begin errors++; $display("FAIL b2b_done_count got %0d want %0d", dones, accepts); end
        if (accepts !== 5) begin errors++; $display("FAIL b2b_accept_count got %0d want 5", accepts); end
        last_exp4 = last;
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] s; logic co, ov, held; int d, r, p, pulses;
        run_op(4, 128'h8000_0000_0000_0001, 128'h8000_0000_0000_0000, 1'b0, 1'b0, last_exp4,
               s, co, ov, d, r, p, held);
        checks += 3;
        if (s !== 128'h1) begin errors++; $display("FAIL pre_abort_sum got %h want 1", s); end
        if (co !== 1'b1) begin errors++; $display("FAIL pre_abort_c_out got %b want 1", co); end
        if (ov !== 1'b1) begin errors++; $display("FAIL pre_abort_ovf got %b want 1", ov); end
        @(negedge clk);
        sel_w = 4; a_v = 128'h5555; b_v = 128'h2222; cin_v = 1'b0; sub_v = 1'b0; start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (obs_sum !== 128'h0) begin errors++; $display("FAIL abort_sum got %h want 0", obs_sum); end
        if (obs_co !== 1'b0) begin errors++; $display("FAIL abort_c_out got %b want 0", obs_co); end
        if (obs_ov !== 1'b0) begin errors++; $display("FAIL abort_ovf got %b want 0", obs_ov); end
        if (obs_done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", obs_done); end
        if (obs_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", obs_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (obs_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", pulses); end
        run_op(4, 128'h1234, 128'h1, 1'b0, 1'b0, 128'h0, s, co, ov, d, r, p, held);
        checks += 3;
        if (s !== 128'h1235) begin errors++; $display("FAIL post_abort_sum got %h want 1235", s); end
        if (d !== 4) begin errors++; $display("FAIL post_abort_latency got %0d want 4", d); end
        if (held !== 1'b1) begin errors++; $display("FAIL post_abort_held got %b want 1", held); end
        last_exp4 = 128'h1235;
    endtask

    task automatic test_random_sweep(input int n, input int count);
        logic [127:0] mask, msb, a, b, es, s, last;
        logic         cin, sb, eco, eov, co, ov, held;
        int           d, r, p, pick;
        mask = '0;
        for (int i = 0; i < 16 * n; i++) mask[i] = 1'b1;
        msb = '0;
        msb[16*n-1] = 1'b1;
        last = '0;
        for (int k = 0; k < count; k++) begin
            a = rand128() & mask;
            b = rand128() & mask;
            pick = int'($urandom_range(0, 7));
            if (pick == 0) a = mask;
            if (pick == 1) a = msb;
            if (pick == 2) b = mask;
            if (pick == 3) b = msb;
            if (pick == 4) b = a;
            cin = 1'($urandom()); sb = 1'($urandom());
            ref_model(16 * n, a, b, cin, sb, es, eco, eov);
            run_op(n, a, b, cin, sb, last, s, co, ov, d, r, p, held);
            checks += 5;
            if (s !== es) begin errors++; $display("FAIL rand%0d_sum got %h want %h", n, s, es); end
            if (co !== eco) begin errors++; $display("FAIL rand%0d_c_out got %b want %b", n, co, eco); end
            if (ov !== eov) begin errors++; $display("FAIL rand%0d_ovf got %b want %b", n, ov, eov); end
            if (d !== n || p !== 1) begin
                errors++; $display("FAIL rand%0d_done got at=%0d pulses=%0d want at=%0d pulses=1", n, d, p, n);
            end
            if (held !== 1'b1) begin errors++; $display("FAIL rand%0d_held got %b want 1", n, held); end
            last = es;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_limb_carry();
        test_add_edges();
        test_sub();
        test_back_to_back();
        test_reset_mid_run();
        test_random_sweep(2, 1500);
        test_random_sweep(8, 1500);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
